dadda_final_adder: RTL and testbench
====================================

# dadda_final_adder

Pipelined carry-propagate adder that closes the Dadda multiplier datapath. It consumes the two rows (sum row and carry row) left by the Dadda reduction tree and produces the final binary result. The add is split into fixed-width segments, one segment per pipeline stage, with the segment carry registered between stages. A valid/ready handshake on both sides supports full throughput and backpressure.

## Interface
- WIDTH, 32: width of each input row and of the result; must be a multiple of SEG, otherwise elaboration fails.
- SEG, 8: bits added per pipeline stage. The number of stages is STAGES = WIDTH/SEG.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  row pair on in_a/in_b is valid.
- in_ready  output  1  block accepts the row pair this cycle.
- in_a  input  WIDTH  sum row from the reduction tree.
- in_b  input  WIDTH  carry row from the reduction tree, already aligned to in_a (no shift inside this block).
- out_valid  output  1  out_sum/out_cout hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH  (in_a + in_b) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage structure:
  - The pipeline has STAGES stages, s1..sSTAGES. Each holds a valid bit, the accumulated low result bits, the not-yet-added high bits of both rows, and one carry bit.
  - s1 adds bits [SEG-1:0] of in_a + in_b with carry-in 0.
  - sk (k>1) adds segment k-1 of the held rows plus the carry registered by s(k-1).
  - Each segment sum is SEG+1 bits wide. The low SEG bits go into the result field; the MSB becomes the next carry.
- The last stage drives out_sum, out_cout and out_valid directly from its registers; there is no extra output register.
- Advance rule (per stage): stage k loads from its upstream when it is empty, or when stage k+1 (or the output) is taking its contents this cycle.
  - adv_last = out_ready || !out_valid.
  - adv_k = !valid_k || adv_(k+1).
  - in_ready = adv_1, which is combinational from out_ready through the valid bits.
- When a stage advances with no upstream data, its valid bit clears. Its data registers may hold stale values; they are don't-care while valid=0.
- A stalled stage holds all of its fields unchanged.
- Results leave in the same order the row pairs entered. No transfer is dropped or duplicated.
- Reset state:
  - All valid bits are 0, all data and carry registers are 0.
  - out_valid=0, out_sum=0, out_cout=0.
  - in_ready=1 as soon as rst_n is high.
- Reset while transfers are in flight discards them all; nothing partial is emitted afterwards.

## Timing
- Latency: a row pair accepted at edge n appears on out_* after edge n+STAGES-1, i.e. STAGES cycles of residency. With defaults the result is visible 4 cycles after acceptance.
- Throughput: one result per cycle while out_ready stays high.
- Capacity: STAGES entries. With out_ready held low, exactly STAGES pairs are accepted, then in_ready drops.
- Full pipeline with out_ready=1: the output transfer and a new input transfer happen in the same cycle, and in_ready stays 1.
- out_sum/out_cout are stable while out_valid=1 and out_ready=0.
- The critical path is one SEG-bit add plus the carry register. The ready chain is combinational across STAGES AND/OR levels.

## Test plan
- Carry propagation (defaults): in_a=0xFFFFFFFF, in_b=0x00000001, single pulse.
  - Required: out_valid rises 4 cycles later with out_sum=0x00000000, out_cout=1.
  - Also: 0x80000000+0x80000000 gives out_sum=0, out_cout=1.
  - Also: 0x12345678+0x0FEDCBA8 gives out_sum=0x22222220, out_cout=0.
- Streaming: 8 consecutive pairs (i, 2i) for i=1..8 with out_ready=1.
  - Required: outputs 3i on 8 consecutive cycles starting at latency 4, all with out_cout=0.
- Backpressure: out_ready=0 while in_valid=1 continuously.
  - Required: exactly 4 pairs accepted, then in_ready=0 and out_sum stable.
  - After out_ready goes to 1, results appear in order with no loss.
- Simultaneous push/pop: pipeline full, out_ready=1 and in_valid=1 in the same cycle.
  - Required: in_ready=1, one result leaves and one pair enters in that cycle, and occupancy stays 4.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 entries in flight.
  - Required: out_valid=0, out_sum=0, out_cout=0 immediately.
  - Required: no stale result after release, and the next accepted pair appears after exactly 4 cycles.
- Random: 10k random in_a/in_b pairs with random in_valid/out_ready.
  - Required: each {out_cout,out_sum} equals in_a+in_b (33-bit) of the matching input, in order.

Source files
------------

// File: rtl/dadda_final_adder.sv
// dadda_final_adder: segmented, pipelined carry-propagate adder closing the Dadda tree.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b upstream; out_valid/out_ready/out_sum/out_cout downstream.
module dadda_final_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int STAGES = WIDTH / SEG;
  // Row registers are only needed by stages that still have segments to add.
  localparam int RS = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % SEG) != 0) begin : g_width_check
    $error("WIDTH must be a multiple of SEG");
  end

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [RS-1:0][WIDTH-1:0]     a_q, a_d;
  logic [RS-1:0][WIDTH-1:0]     b_q, b_d;
  logic [STAGES-1:0][SEG:0]     seg_sum;
  logic [STAGES-1:0]            adv;
  logic                         adv_run;

  always_comb begin
    seg_sum = '0;
    seg_sum[0] = {1'b0, in_a[SEG-1:0]}
               + {1'b0, in_b[SEG-1:0]};
    for (int k = 1; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_q[k-1][k*SEG +: SEG]}
                 + {1'b0, b_q[k-1][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, carry_q[k-1]};
    end
  end

  // Ready ripples back from the output through each stage's valid bit.
  always_comb begin
    adv = '0;
    adv_run = out_ready || !valid_q[STAGES-1];
    adv[STAGES-1] = adv_run;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_run = !valid_q[k] || adv_run;
      adv[k] = adv_run;
    end
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        res_d[0] = '0;
        res_d[0][SEG-1:0] = seg_sum[0][SEG-1:0];
        carry_d[0] = seg_sum[0][SEG];
        if (STAGES > 1) begin
          a_d[0] = in_a;
          b_d[0] = in_b;
        end
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          res_d[k] = res_q[k-1];
          res_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
          carry_d[k] = seg_sum[k][SEG];
          if (k < STAGES - 1) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = res_q[STAGES-1];
  assign out_cout  = carry_q[STAGES-1];

endmodule

// File: tb/tb_dadda_final_adder.sv
// tb_dadda_final_adder: randomized and directed bench with an in-order scoreboard.
// Ports: none; drives dadda_final_adder with default WIDTH=32, SEG=8.
module tb_dadda_final_adder;

  localparam int W  = 32;
  localparam int SG = 8;
  localparam int ST = W / SG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;

  dadda_final_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W:0] exp_q[$];
  int         cyc_q[$];
  int         cyc = 0;
  int         acc_cnt = 0;
  bit         lat_chk = 1'b0;
  logic [W:0] e;
  int         pc;

  // Scoreboard: transfers are decided by values held mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(1), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          pc = cyc_q.pop_front();
          check("result", 64'({out_cout, out_sum}), 64'(e));
          if (lat_chk) check("latency", 64'(cyc - pc), 64'(ST));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        cyc_q.push_back(cyc);
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b);
    logic r;
    bit   done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int n = 0; n < 100 && !done; n++) begin
      r = in_ready;
      step();
      done = r;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) step();
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  int           acc0;
  logic [W-1:0] hold;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_cout", 64'(out_cout), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    step();

    // Carry propagation with unstalled latency check.
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001);
    in_valid = 1'b0;
    drain(20);
    send(32'h8000_0000, 32'h8000_0000);
    in_valid = 1'b0;
    drain(20);
    send(32'h1234_5678, 32'h0FED_CBA8);
    in_valid = 1'b0;
    drain(20);

    // Streaming back-to-back pairs.
    for (int i = 1; i <= 8; i++) send(W'(i), W'(2 * i));
    in_valid = 1'b0;
    drain(30);

    // Backpressure: pipeline fills to capacity and holds.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      step();
    end
    check("bp_accepts", 64'(acc_cnt - acc0), 64'(ST));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    hold = out_sum;
    step();
    step();
    check("bp_stable", 64'(out_sum), 64'(hold));

    // Simultaneous push and pop on a full pipeline.
    out_ready = 1'b1;
    in_a = $urandom;
    in_b = $urandom;
    #1;
    check("pp_in_ready", 64'(in_ready), 64'(1));
    check("pp_out_valid", 64'(out_valid), 64'(1));
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    #1;
    check("pp_occupancy", 64'(exp_q.size()), 64'(ST));
    check("pp_full", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    drain(50);

    // Reset with three entries in flight.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_sum", 64'(out_sum), 64'(0));
    check("mid_rst_cout", 64'(out_cout), 64'(0));
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    repeat (8) step();
    check("post_rst_idle", 64'(out_valid), 64'(0));
    send(32'hDEAD_BEEF, 32'h2152_4111);
    in_valid = 1'b0;
    drain(20);

    // Random traffic with random backpressure.
    lat_chk = 1'b0;
    acc0 = acc_cnt;
    for (int c = 0; c < 60000 && (acc_cnt - acc0) < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      in_b = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("rand_accepts", 64'((acc_cnt - acc0) >= 10000), 64'(1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
